vector_loader: RTL and testbench

VECTOR_LOADER -- requirements
Module: vector_loader

---
 rtl/vector_loader.sv | 88 ++++++++
 tb/tb_vector_loader.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/vector_loader.sv
// vector_loader: double-buffered loader that packs two MATRIXSIZE-element vectors from a beat stream
module vector_loader #(
   parameter int MATRIXSIZE = 10,
   parameter int INTSIZE    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [INTSIZE-1:0]            in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          clear,
   output logic [INTSIZE*MATRIXSIZE-1:0] out_a_flat,
   output logic [INTSIZE*MATRIXSIZE-1:0] out_b_flat,
   output logic                          out_valid,
   input  logic                          out_ready
);
   localparam int IW = MATRIXSIZE > 1 ? $clog2(MATRIXSIZE) : 1;
   localparam int W = INTSIZE * MATRIXSIZE;
   localparam logic [IW-1:0] LAST = IW'(MATRIXSIZE - 1);
   typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic [W-1:0] stage_a_q, stage_a_d, stage_b_q, stage_b_d;
   logic [W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic accept, slot_free;
   assign accept = in_valid & in_ready_q;
   assign slot_free = ~out_valid_q | out_ready;
   always_comb begin
      state_d = state_q;
      idx_d = idx_q;
      stage_a_d = stage_a_q;
      stage_b_d = stage_b_q;
      out_a_d = out_a_q;
      out_b_d = out_b_q;
      out_valid_d = out_valid_q & ~out_ready;
      if (clear) begin
         state_d = LOAD_A;
         idx_d = '0;
      end else begin
         case (state_q)
            LOAD_A, LOAD_B: if (accept) begin
               for (int e = 0; e < MATRIXSIZE; e++) begin
                  if (int'(idx_q) == e && state_q == LOAD_A) stage_a_d[W-1-e*INTSIZE -: INTSIZE] = in_data;
                  if (int'(idx_q) == e && state_q == LOAD_B) stage_b_d[W-1-e*INTSIZE -: INTSIZE] = in_data;
               end
               idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
               if (idx_q == LAST) state_d = (state_q == LOAD_A) ? LOAD_B : FULL;
            end
            FULL: if (slot_free) begin
               out_a_d = stage_a_q;
               out_b_d = stage_b_q;
               out_valid_d = 1'b1;
               state_d = LOAD_A;
               idx_d = '0;
            end
            default: state_d = LOAD_A;
         endcase
      end
      in_ready_d = (state_d != FULL);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         idx_q <= '0;
         in_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         stage_a_q <= '0;
         stage_b_q <= '0;
         out_a_q <= '0;
         out_b_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         in_ready_q <= in_ready_d;
         out_valid_q <= out_valid_d;
         stage_a_q <= stage_a_d;
         stage_b_q <= stage_b_d;
         out_a_q <= out_a_d;
         out_b_q <= out_b_d;
      end
   end
   assign in_ready = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_a_flat = out_a_q;
   assign out_b_flat = out_b_q;
endmodule

// File: tb/tb_vector_loader.sv
// tb_vector_loader: directed and random stimulus against a queue-based model of the loader
module tb_vector_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] in_data = '0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic clear = 1'b0;
   logic [23:0] out_a_flat, out_b_flat;
   logic out_valid;
   logic out_ready = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [7:0] stage[$];
   logic [23:0] exp_a = '0, exp_b = '0;
   logic exp_valid = 1'b0, exp_ready = 1'b0;
   vector_loader #(.MATRIXSIZE(3), .INTSIZE(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .clear(clear), .out_a_flat(out_a_flat), .out_b_flat(out_b_flat), .out_valid(out_valid),
      .out_ready(out_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".in_ready"}, {23'd0, in_ready}, {23'd0, exp_ready});
      chk({tag, ".out_valid"}, {23'd0, out_valid}, {23'd0, exp_valid});
      chk({tag, ".out_a"}, out_a_flat, exp_a);
      chk({tag, ".out_b"}, out_b_flat, exp_b);
   endtask
   // Model: a pair is complete once six beats are queued; inputs are sampled just before the edge.
   task automatic model_edge();
      logic acc, free;
      if (!rst_n) return;
      acc = in_valid && exp_ready;
      free = !exp_valid || out_ready;
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (clear) stage.delete();
      else if (stage.size() == 6 && free) begin
         exp_a = {stage[0], stage[1], stage[2]};
         exp_b = {stage[3], stage[4], stage[5]};
         exp_valid = 1'b1;
         stage.delete();
      end else if (acc) stage.push_back(in_data);
      exp_ready = (stage.size() < 6);
   endtask
   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask
   task automatic beat(input logic [7:0] d, input string tag);
      in_valid = 1'b1;
      in_data = d;
      tick(tag);
      in_valid = 1'b0;
   endtask
   task automatic async_reset(input string tag);
      rst_n = 1'b0;
      #1;
      stage.delete();
      exp_valid = 1'b0;
      exp_ready = 1'b0;
      exp_a = '0;
      exp_b = '0;
      check_all(tag);
      tick({tag, "_held"});
      rst_n = 1'b1;
      tick({tag, "_release"});
      chk({tag, ".ready_after_release"}, {23'd0, in_ready}, 24'd1);
   endtask
   initial begin
      #2;
      async_reset("reset");
      for (int i = 1; i <= 6; i++) beat(8'(i), "load1");
      chk("req32.valid_before_copy", {23'd0, out_valid}, 24'd0);
      tick("req32_copy");
      chk("req32.a", out_a_flat, 24'h010203);
      chk("req32.b", out_b_flat, 24'h040506);
      chk("req32.valid", {23'd0, out_valid}, 24'd1);
      for (int i = 7; i <= 12; i++) beat(8'(i), "load2");
      tick("hold1");
      tick("hold2");
      chk("req33.hold_a", out_a_flat, 24'h010203);
      chk("req33.hold_ready", {23'd0, in_ready}, 24'd0);
      out_ready = 1'b1;
      tick("req33_pulse");
      out_ready = 1'b0;
      chk("req33.a", out_a_flat, 24'h070809);
      chk("req33.b", out_b_flat, 24'h0A0B0C);
      chk("req33.valid", {23'd0, out_valid}, 24'd1);
      chk("req33.ready", {23'd0, in_ready}, 24'd1);
      out_ready = 1'b1;
      tick("drain1");
      out_ready = 1'b0;
      chk("drain1.valid", {23'd0, out_valid}, 24'd0);
      chk("drain1.a_kept", out_a_flat, 24'h070809);
      for (int i = 1; i <= 6; i++) begin
         tick("gap");
         beat(8'(i), "toggle");
      end
      tick("req34_copy");
      chk("req34.a", out_a_flat, 24'h010203);
      chk("req34.b", out_b_flat, 24'h040506);
      for (int i = 0; i < 4; i++) beat(8'hA0 + 8'(i), "pre_clear");
      clear = 1'b1;
      tick("clear");
      clear = 1'b0;
      chk("req35.a_during_clear", out_a_flat, 24'h010203);
      chk("req35.valid_during_clear", {23'd0, out_valid}, 24'd1);
      for (int i = 'h11; i <= 'h16; i++) beat(8'(i), "after_clear");
      out_ready = 1'b1;
      tick("req35_copy");
      chk("req35.a", out_a_flat, 24'h111213);
      chk("req35.b", out_b_flat, 24'h141516);
      tick("drain2");
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) beat(8'h20 + 8'(i), "pre_clear6");
      clear = 1'b1;
      beat(8'h26, "clear_with_6th");
      clear = 1'b0;
      tick("after_clear6_a");
      tick("after_clear6_b");
      chk("req36.no_valid", {23'd0, out_valid}, 24'd0);
      chk("req36.ready", {23'd0, in_ready}, 24'd1);
      for (int i = 1; i <= 6; i++) beat(8'h30 + 8'(i), "fill_full1");
      tick("copy_full1");
      for (int i = 1; i <= 6; i++) beat(8'h40 + 8'(i), "fill_full2");
      tick("stuck_full");
      clear = 1'b1;
      out_ready = 1'b1;
      tick("clear_in_full");
      clear = 1'b0;
      out_ready = 1'b0;
      chk("clear_full.valid", {23'd0, out_valid}, 24'd0);
      chk("clear_full.a_kept", out_a_flat, 24'h313233);
      chk("clear_full.ready", {23'd0, in_ready}, 24'd1);
      for (int i = 1; i <= 4; i++) beat(8'h50 + 8'(i), "mid_b");
      #3;
      async_reset("reset_mid_b");
      for (int n = 0; n < 400; n++) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_data = 8'($urandom);
         out_ready = ($urandom_range(0, 2) == 0);
         clear = ($urandom_range(0, 19) == 0);
         tick("rand");
      end
      in_valid = 1'b0;
      clear = 1'b0;
      out_ready = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
